// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared Q-format constants and divider state encoding
package fixed_point_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int FRAC_BITS_DEF = 10;

  localparam logic [WIDTH_DEF-1:0] MAX_POS = 16'h7FFF;
  localparam logic [WIDTH_DEF-1:0] MIN_NEG = 16'h8000;

  // Restoring steps per division in the truncating build
  localparam int N_STEPS = WIDTH_DEF + FRAC_BITS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational restoring-division iteration
module div_restoring_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_shift = {rem, dividend_msb};
    diff      = rem_shift[WIDTH:0] - {1'b0, b_mag};
    q_bit     = (rem_shift >= {2'b00, b_mag});
    rem_next  = q_bit ? diff : rem_shift[WIDTH:0];
  end

endmodule

// File: rtl/divider_fixed_point_restoring.sv
// rtl/divider_fixed_point_restoring.sv - sequential signed Q-format divider; DIVIDER_ROUND_NEAREST_EN adds a guard bit for round-half-away
module divider_fixed_point_restoring
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag,
  output logic             div_by_zero,
  output logic             finish
);

`ifdef DIVIDER_ROUND_NEAREST_EN
  localparam int NSTEPS = WIDTH + FRAC_BITS + 1;
`else
  localparam int NSTEPS = WIDTH + FRAC_BITS;
`endif
  localparam int CW = $clog2(NSTEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

  localparam logic [WIDTH-1:0]  SAT_POS     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]  SAT_NEG     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NSTEPS-1:0] MAG_POS_LIM = {{(NSTEPS-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [NSTEPS-1:0] MAG_NEG_LIM = {{(NSTEPS-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  div_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NSTEPS-1:0] dividend_q, dividend_d;
  logic [NSTEPS-1:0] quo_q, quo_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  b_mag_q, b_mag_d;
  logic              sign_q, sign_d;
  logic              a_neg_q, a_neg_d;
  logic              dbz_q, dbz_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              dbz_out_q, dbz_out_d;
  logic              finish_q, finish_d;

  logic [WIDTH:0]    rem_next;
  logic              q_bit;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag_in;
  logic [NSTEPS-1:0] mag;
  logic [WIDTH-1:0]  mag_w;

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_q),
    .dividend_msb (dividend_q[NSTEPS-1]),
    .b_mag        (b_mag_q),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_comb begin
    a_mag    = A[WIDTH-1] ? (~A + 1'b1) : A;
    b_mag_in = B[WIDTH-1] ? (~B + 1'b1) : B;
`ifdef DIVIDER_ROUND_NEAREST_EN
    // Lowest quotient bit is the guard; adding it rounds half away from zero
    mag = (quo_q >> 1) + {{(NSTEPS-1){1'b0}}, quo_q[0]};
`else
    mag = quo_q;
`endif
    mag_w = mag[WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    b_mag_d    = b_mag_q;
    sign_d     = sign_q;
    a_neg_d    = a_neg_q;
    dbz_d      = dbz_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    dbz_out_d  = dbz_out_q;
    finish_d   = finish_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          cnt_d      = '0;
          dividend_d = {a_mag, {(NSTEPS-WIDTH){1'b0}}};
          quo_d      = '0;
          rem_d      = '0;
          b_mag_d    = b_mag_in;
          sign_d     = A[WIDTH-1] ^ B[WIDTH-1];
          a_neg_d    = A[WIDTH-1];
          dbz_d      = (B == '0);
        end
      end
      CALC: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          dividend_d = {dividend_q[NSTEPS-2:0], 1'b0};
          rem_d      = rem_next;
          quo_d      = {quo_q[NSTEPS-2:0], q_bit};
          if (cnt_q == LAST_STEP) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          finish_d = 1'b1;
          if (dbz_q) begin
            result_d  = a_neg_q ? SAT_NEG : SAT_POS;
            ovf_d     = 1'b1;
            dbz_out_d = 1'b1;
          end else if (!sign_q && (mag > MAG_POS_LIM)) begin
            result_d  = SAT_POS;
            ovf_d     = 1'b1;
            dbz_out_d = 1'b0;
          end else if (sign_q && (mag > MAG_NEG_LIM)) begin
            result_d  = SAT_NEG;
            ovf_d     = 1'b1;
            dbz_out_d = 1'b0;
          end else begin
            result_d  = sign_q ? (~mag_w + 1'b1) : mag_w;
            ovf_d     = 1'b0;
            dbz_out_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_d  = IDLE;
          finish_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      b_mag_q    <= '0;
      sign_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      dbz_q      <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      dbz_out_q  <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      b_mag_q    <= b_mag_d;
      sign_q     <= sign_d;
      a_neg_q    <= a_neg_d;
      dbz_q      <= dbz_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      dbz_out_q  <= dbz_out_d;
      finish_q   <= finish_d;
    end
  end

  assign result        = result_q;
  assign overflow_flag = ovf_q;
  assign div_by_zero   = dbz_out_q;
  assign finish        = finish_q;

endmodule

// File: tb/tb_divider_fixed_point_restoring.sv
// tb/tb_divider_fixed_point_restoring.sv - table-driven checks of the restoring divider
module tb_divider_fixed_point_restoring;
  import fixed_point_pkg::*;

`ifdef DIVIDER_ROUND_NEAREST_EN
  localparam int LAT = N_STEPS + 2;
  localparam logic [15:0] EXP_2_3   = 16'h02AB;
  localparam logic [15:0] EXP_HALFN = 16'hFFFF;
`else
  localparam int LAT = N_STEPS + 1;
  localparam logic [15:0] EXP_2_3   = 16'h02AA;
  localparam logic [15:0] EXP_HALFN = 16'h0000;
`endif

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        dbz;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        start = 1'b0;
  logic [15:0] result;
  logic        overflow_flag;
  logic        div_by_zero;
  logic        finish;

  int checks = 0;
  int failures = 0;

  vec_t vecs[11];

  divider_fixed_point_restoring dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .start         (start),
    .result        (result),
    .overflow_flag (overflow_flag),
    .div_by_zero   (div_by_zero),
    .finish        (finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Accepting edge is the first posedge after start rises; edges counted from there
  task automatic run_op(input vec_t v);
    @(negedge clk);
    A = v.a;
    B = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 16'hA5A5;
    B = 16'h0003;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      if (k == LAT - 1) chk({v.name, " finish_early"}, {31'b0, finish}, 32'd0);
    end
    chk({v.name, " finish"}, {31'b0, finish}, 32'd1);
    chk({v.name, " result"}, {16'b0, result}, {16'b0, v.res});
    chk({v.name, " ovf"}, {31'b0, overflow_flag}, {31'b0, v.ovf});
    chk({v.name, " dbz"}, {31'b0, div_by_zero}, {31'b0, v.dbz});
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({v.name, " finish_clear"}, {31'b0, finish}, 32'd0);
    chk({v.name, " result_hold"}, {16'b0, result}, {16'b0, v.res});
  endtask

  initial begin
    bit seen_finish;

    vecs[0]  = '{"3/2",      16'h0C00, 16'h0800, 16'h0600, 1'b0, 1'b0};
    vecs[1]  = '{"-1/4",     16'hFC00, 16'h1000, 16'hFF00, 1'b0, 1'b0};
    vecs[2]  = '{"16/0.0625",16'h4000, 16'h0040, 16'h7FFF, 1'b1, 1'b0};
    vecs[3]  = '{"-16/0.06", 16'hC000, 16'h0040, 16'h8000, 1'b1, 1'b0};
    vecs[4]  = '{"2/3",      16'h0800, 16'h0C00, EXP_2_3,  1'b0, 1'b0};
    vecs[5]  = '{"1/-1",     16'h0400, 16'hFC00, 16'hFC00, 1'b0, 1'b0};
    vecs[6]  = '{"-32/-1",   16'h8000, 16'hFC00, 16'h7FFF, 1'b1, 1'b0};
    vecs[7]  = '{"-32/1",    16'h8000, 16'h0400, 16'h8000, 1'b0, 1'b0};
    vecs[8]  = '{"lsb/-2",   16'h0001, 16'hF800, EXP_HALFN,1'b0, 1'b0};
    vecs[9]  = '{"1/0",      16'h0400, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
    vecs[10] = '{"-1/0",     16'hFC00, 16'h0000, 16'h8000, 1'b1, 1'b1};

    #12;
    chk("reset result", {16'b0, result}, 32'd0);
    chk("reset ovf", {31'b0, overflow_flag}, 32'd0);
    chk("reset dbz", {31'b0, div_by_zero}, 32'd0);
    chk("reset finish", {31'b0, finish}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // Asynchronous reset during CALC clears outputs without waiting for a clock edge
    @(negedge clk);
    A = 16'h0C00;
    B = 16'h0800;
    start = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid result", {16'b0, result}, 32'd0);
    chk("rst_mid ovf", {31'b0, overflow_flag}, 32'd0);
    chk("rst_mid dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst_mid finish", {31'b0, finish}, 32'd0);
    chk("rst_mid state", {30'b0, dut.state_q}, {30'b0, IDLE});
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_op(vecs[0]);

    // Start dropped after edge 10 aborts: finish never rises, outputs hold
    @(negedge clk);
    A = 16'hFC00;
    B = 16'h1000;
    start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen_finish = 1'b0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(posedge clk);
      #1;
      if (finish) seen_finish = 1'b1;
    end
    chk("abort finish_never", {31'b0, seen_finish}, 32'd0);
    chk("abort result", {16'b0, result}, 32'h0600);
    chk("abort ovf", {31'b0, overflow_flag}, 32'd0);
    chk("abort state", {30'b0, dut.state_q}, {30'b0, IDLE});

    run_op(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider_fixed_point_restoring.md
Name: divider_fixed_point_restoring

Overview:
- Sequential signed fixed-point divider; the inverse datapath to the modified-Booth multiplier in the Fixed Point Arithmetic library.
- Computes result = A / B in the same 16-bit Q format.
- Uses the same start/finish level handshake and overflow saturation rules as the multiplier, so the ODE solver datapath can swap the two units.
- Radix-2 restoring algorithm on operand magnitudes, with sign fix-up and saturation at the end.

Parameters:
- WIDTH, 16, operand/result width (two's complement)
- FRAC_BITS, 10, fractional bits of the Q format (default Q5.10)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- A  in  WIDTH  dividend, signed fixed point
- B  in  WIDTH  divisor, signed fixed point
- start  in  1  level request; held high until finish is seen
- result  out  WIDTH  quotient, saturated
- overflow_flag  out  1  quotient out of range or divide-by-zero
- div_by_zero  out  1  B was zero
- finish  out  1  result valid; held while start stays high

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; result=0, overflow_flag=0, div_by_zero=0, finish=0; all internal registers cleared. Reset mid-operation aborts with no output update.
- States: IDLE, CALC, FIX, DONE.
- IDLE -> CALC on a rising edge with start=1.
  - Latch |A|, |B|, sign = A[WIDTH-1]^B[WIDTH-1], dbz = (B==0).
  - Dividend register = |A| << FRAC_BITS (WIDTH+FRAC_BITS bits). Remainder = 0. Iteration counter = 0.
  - |A| is WIDTH bits unsigned, so -2^(WIDTH-1) is representable.
- CALC: one restoring step per cycle, N = WIDTH+FRAC_BITS steps (26 by default).
  - Shift next dividend MSB into remainder. Trial-subtract |B|. Set quotient bit if non-negative, else restore.
  - Remainder width is WIDTH+1.
  - After step N, go to FIX.
- FIX: apply sign and saturation, register outputs, then go to DONE.
  - dbz: result = 0x8000 if A is negative, else 0x7FFF; overflow_flag=1, div_by_zero=1.
  - Positive result with magnitude > 2^(WIDTH-1)-1: result=0x7FFF, overflow_flag=1.
  - Negative result with magnitude > 2^(WIDTH-1): result=0x8000, overflow_flag=1.
  - Otherwise result = signed magnitude, overflow_flag=0. A negative sign with zero magnitude gives 0.
  - Rounding: truncate toward zero.
- DONE: finish=1; outputs hold while start=1. When start=0, go to IDLE and clear finish; result and flags keep their last values.
- Latency: finish rises N+1 clock edges after the accepting edge (27 by default). Latency is fixed, including the dbz case.
- start dropped during CALC or FIX: abort to IDLE; finish stays 0; outputs unchanged.
- A and B are sampled only on the accepting edge; later changes are ignored.
- Back-to-back operations need at least one cycle with start=0 between them.

Optional Feature:
- Macro: DIVIDER_ROUND_NEAREST_EN
- Defined:
  - Runs N+1 steps; the extra quotient bit is a guard bit.
  - Magnitude = (q >> 1) + guard, i.e. round half away from zero, applied before the saturation check.
  - finish rises at N+2 edges after accept.
- Undefined: truncation, with latency N+1.

Decomposition:
- Package fixed_point_pkg holds:
  - WIDTH and FRAC_BITS defaults
  - MAX_POS (0x7FFF) and MIN_NEG (0x8000) constants
  - state encoding: IDLE, CALC, FIX, DONE
  - latency constant N
- Sub-module div_restoring_step: combinational single iteration.
  - Inputs: remainder, dividend MSB, |B|.
  - Outputs: next remainder, quotient bit.
- The top module holds the FSM, counter, registers and fix-up logic.

Test Plan:
- A=0x0C00 (3.0), B=0x0800 (2.0), start held -> finish at edge 27, result=0x0600 (1.5), overflow_flag=0, div_by_zero=0; finish=0 at edge 26.
- A=0xFC00 (-1.0), B=0x1000 (4.0) -> result=0xFF00 (-0.25), overflow_flag=0.
- A=0x4000 (16.0), B=0x0040 (0.0625) -> result=0x7FFF, overflow_flag=1; A=0xC000, same B -> result=0x8000, overflow_flag=1.
- A=0xFC00, B=0x0000 -> result=0x8000, overflow_flag=1, div_by_zero=1, still at edge 27.
- A=0x0800, B=0x0C00 (2/3) -> result=0x02AA; with DIVIDER_ROUND_NEAREST_EN -> 0x02AB, finish at edge 28.
- rst pulsed low mid-CALC -> immediate result=0, finish=0, state IDLE. Separately, start dropped at edge 10 -> finish never asserts and outputs are unchanged.
